// File: rtl/aclk_pkg.sv
// rtl/aclk_pkg.sv - shared types and BCD helpers for the multi-alarm clock
package aclk_pkg;

   localparam int MAX_ALARMS = 8;

   typedef struct packed {
      logic [1:0] h1;
      logic [3:0] h0;
      logic [3:0] m1;
      logic [3:0] m0;
   } bcd_hm_t;

   typedef struct packed {
      logic [1:0] h1;
      logic [3:0] h0;
      logic [3:0] m1;
      logic [3:0] m0;
      logic [3:0] s1;
      logic [3:0] s0;
   } bcd_time_t;

   typedef enum logic [1:0] {
      AL_IDLE    = 2'd0,
      AL_RINGING = 2'd1,
      AL_SNOOZED = 2'd2
   } al_state_e;

   // HH:MM is a legal 24h time with every digit a proper BCD digit
   function automatic logic bcd_hm_valid(input bcd_hm_t t);
      return (t.h0 <= 4'd9) && (t.m1 <= 4'd5) && (t.m0 <= 4'd9) &&
             ((t.h1 < 2'd2) || ((t.h1 == 2'd2) && (t.h0 <= 4'd3)));
   endfunction

   // One second later, rippling carries up to the hours and wrapping at 24h
   function automatic bcd_time_t bcd_time_inc(input bcd_time_t t);
      bcd_time_t n;
      n = t;
      if (t.s0 != 4'd9) n.s0 = t.s0 + 4'd1;
      else begin
         n.s0 = 4'd0;
         if (t.s1 != 4'd5) n.s1 = t.s1 + 4'd1;
         else begin
            n.s1 = 4'd0;
            if (t.m0 != 4'd9) n.m0 = t.m0 + 4'd1;
            else begin
               n.m0 = 4'd0;
               if (t.m1 != 4'd5) n.m1 = t.m1 + 4'd1;
               else begin
                  n.m1 = 4'd0;
                  if ((t.h1 == 2'd2) && (t.h0 == 4'd3)) begin
                     n.h1 = 2'd0;
                     n.h0 = 4'd0;
                  end else if (t.h0 == 4'd9) begin
                     n.h0 = 4'd0;
                     n.h1 = t.h1 + 2'd1;
                  end else begin
                     n.h0 = t.h0 + 4'd1;
                  end
               end
            end
         end
      end
      return n;
   endfunction

   // HH:MM plus a number of minutes, wrapping at 24h
   function automatic bcd_hm_t bcd_add_min(input bcd_hm_t t, input int unsigned dm);
      int unsigned tot;
      int unsigned hh;
      int unsigned mm;
      bcd_hm_t r;
      tot = (32'(t.h1) * 10 + 32'(t.h0)) * 60 + 32'(t.m1) * 10 + 32'(t.m0) + dm;
      tot = tot % 1440;
      hh = tot / 60;
      mm = tot % 60;
      r.h1 = 2'(hh / 10);
      r.h0 = 4'(hh % 10);
      r.m1 = 4'(mm / 10);
      r.m0 = 4'(mm % 10);
      return r;
   endfunction

endpackage

// File: rtl/aclk_alarm_chan.sv
// rtl/aclk_alarm_chan.sv - one alarm channel: alarm register, ring FSM, ring counter (snooze with ACLK_SNOOZE_EN)
module aclk_alarm_chan
   import aclk_pkg::*;
#(
   parameter int RING_SEC   = 60
`ifdef ACLK_SNOOZE_EN
   ,
   parameter int SNOOZE_MIN = 5
`endif
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      ld_en,
   input  bcd_hm_t   ld_hm,
   input  logic      adv,
   input  bcd_time_t next_time,
   input  logic      sec_tick,
   input  logic      al_on,
   input  logic      stop_al,
`ifdef ACLK_SNOOZE_EN
   input  logic      snooze,
   input  bcd_hm_t   cur_hm,
`endif
   output logic      alarm
);

   bcd_hm_t   al_q;
   al_state_e state_q;
   logic [7:0] ring_q;
   bcd_hm_t   nxt_hm;
   logic      at_min;
   logic      match;
`ifdef ACLK_SNOOZE_EN
   bcd_hm_t   tgt_q;
`endif

   assign nxt_hm = {next_time.h1, next_time.h0, next_time.m1, next_time.m0};
   assign at_min = adv && (next_time.s1 == 4'd0) && (next_time.s0 == 4'd0);
   assign match  = at_min && al_on && (nxt_hm == al_q);

   // alarm time register, written only by validated loads aimed at this channel
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) al_q <= '0;
      else if (ld_en) al_q <= ld_hm;
   end

   // ring state machine; stop and disarm win over everything else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= AL_IDLE;
         ring_q  <= '0;
         alarm   <= 1'b0;
`ifdef ACLK_SNOOZE_EN
         tgt_q   <= '0;
`endif
      end else begin
         case (state_q)
            AL_IDLE: begin
               if (!stop_al && match) begin
                  state_q <= AL_RINGING;
                  ring_q  <= 8'(RING_SEC);
                  alarm   <= 1'b1;
               end
            end
            AL_RINGING: begin
               if (stop_al || !al_on) begin
                  state_q <= AL_IDLE;
                  alarm   <= 1'b0;
`ifdef ACLK_SNOOZE_EN
               end else if (snooze) begin
                  state_q <= AL_SNOOZED;
                  tgt_q   <= bcd_add_min(cur_hm, SNOOZE_MIN);
                  alarm   <= 1'b0;
`endif
               end else if (sec_tick) begin
                  if (ring_q <= 8'd1) begin
                     state_q <= AL_IDLE;
                     alarm   <= 1'b0;
                  end else begin
                     ring_q <= ring_q - 8'd1;
                  end
               end
            end
`ifdef ACLK_SNOOZE_EN
            AL_SNOOZED: begin
               if (stop_al || !al_on) begin
                  state_q <= AL_IDLE;
               end else if (at_min && (nxt_hm == tgt_q)) begin
                  state_q <= AL_RINGING;
                  ring_q  <= 8'(RING_SEC);
                  alarm   <= 1'b1;
               end
            end
`endif
            default: begin
               state_q <= AL_IDLE;
               alarm   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/aclock_multi.sv
// rtl/aclock_multi.sv - multi-alarm 24h BCD alarm clock top (snooze built with ACLK_SNOOZE_EN)
module aclock_multi
   import aclk_pkg::*;
#(
   parameter int NUM_ALARMS    = 4,
   parameter int TICKS_PER_SEC = 10,
   parameter int RING_SEC      = 60,
   parameter int SNOOZE_MIN    = 5,
   localparam int SEL_W        = $clog2(NUM_ALARMS + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            H_in1,
   input  logic [3:0]            H_in0,
   input  logic [3:0]            M_in1,
   input  logic [3:0]            M_in0,
   input  logic                  LD_time,
   input  logic                  LD_alarm,
   input  logic [SEL_W-1:0]      al_sel,
   input  logic [NUM_ALARMS-1:0] AL_ON,
   input  logic                  STOP_al,
`ifdef ACLK_SNOOZE_EN
   input  logic                  SNOOZE,
`endif
   output logic [NUM_ALARMS-1:0] Alarm,
   output logic [1:0]            H_out1,
   output logic [3:0]            H_out0,
   output logic [3:0]            M_out1,
   output logic [3:0]            M_out0,
   output logic [3:0]            S_out1,
   output logic [3:0]            S_out0,
   output logic                  load_err
);

   localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);

   if ((NUM_ALARMS < 1) || (NUM_ALARMS > MAX_ALARMS) || (TICKS_PER_SEC < 1) ||
       (RING_SEC < 1) || (RING_SEC > 255) || (SNOOZE_MIN < 1) || (SNOOZE_MIN > 59)) begin : g_bad_param
      $error("aclock_multi: parameter out of range");
   end

   logic [TW-1:0] tick_q;
   bcd_time_t     time_q;
   bcd_time_t     next_time;
   bcd_hm_t       in_hm;
   logic          in_valid;
   logic          sel_ok;
   logic          ld_time_ok;
   logic          ld_alarm_ok;
   logic          sec_tick;
   logic          adv;

   assign in_hm       = {H_in1, H_in0, M_in1, M_in0};
   assign in_valid    = bcd_hm_valid(in_hm);
   assign sel_ok      = (32'(al_sel) < NUM_ALARMS);
   assign ld_time_ok  = LD_time && in_valid;
   assign ld_alarm_ok = LD_alarm && in_valid && sel_ok;
   assign sec_tick    = (tick_q == TICK_MAX);
   assign adv         = sec_tick && !ld_time_ok;
   assign next_time   = bcd_time_inc(time_q);

   // second divider and time-of-day counter; a valid time load beats the tick
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_q <= '0;
         time_q <= '0;
      end else if (ld_time_ok) begin
         tick_q <= '0;
         time_q <= {in_hm, 4'd0, 4'd0};
      end else begin
         tick_q <= sec_tick ? '0 : tick_q + 1'b1;
         if (sec_tick) time_q <= next_time;
      end
   end

   // one-cycle flag for any rejected time or alarm load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) load_err <= 1'b0;
      else        load_err <= (LD_time && !in_valid) || (LD_alarm && !(in_valid && sel_ok));
   end

   for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_chan
      aclk_alarm_chan #(
         .RING_SEC   (RING_SEC)
`ifdef ACLK_SNOOZE_EN
         ,
         .SNOOZE_MIN (SNOOZE_MIN)
`endif
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .ld_en     (ld_alarm_ok && (al_sel == SEL_W'(i))),
         .ld_hm     (in_hm),
         .adv       (adv),
         .next_time (next_time),
         .sec_tick  (sec_tick),
         .al_on     (AL_ON[i]),
         .stop_al   (STOP_al),
`ifdef ACLK_SNOOZE_EN
         .snooze    (SNOOZE),
         .cur_hm    ({time_q.h1, time_q.h0, time_q.m1, time_q.m0}),
`endif
         .alarm     (Alarm[i])
      );
   end

   assign H_out1 = time_q.h1;
   assign H_out0 = time_q.h0;
   assign M_out1 = time_q.m1;
   assign M_out0 = time_q.m0;
   assign S_out1 = time_q.s1;
   assign S_out0 = time_q.s0;

endmodule

// File: tb/tb_aclock_multi.sv
// tb/tb_aclock_multi.sv - directed self-checking bench for aclock_multi
module tb_aclock_multi;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] H_in1 = '0;
   logic [3:0] H_in0 = '0;
   logic [3:0] M_in1 = '0;
   logic [3:0] M_in0 = '0;
   logic       LD_time = 1'b0;
   logic       LD_alarm = 1'b0;
   logic [2:0] al_sel = '0;
   logic [3:0] AL_ON = '0;
   logic       STOP_al = 1'b0;
`ifdef ACLK_SNOOZE_EN
   logic       SNOOZE = 1'b0;
`endif
   logic [3:0] Alarm;
   logic [1:0] H_out1;
   logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;
   logic       load_err;
   logic [23:0] now_t;

   int checks = 0;
   int errors = 0;

   aclock_multi #(
      .NUM_ALARMS(4), .TICKS_PER_SEC(1), .RING_SEC(3), .SNOOZE_MIN(5)
   ) dut (
      .clk(clk), .reset(reset),
      .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
      .LD_time(LD_time), .LD_alarm(LD_alarm), .al_sel(al_sel), .AL_ON(AL_ON),
      .STOP_al(STOP_al),
`ifdef ACLK_SNOOZE_EN
      .SNOOZE(SNOOZE),
`endif
      .Alarm(Alarm),
      .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
      .S_out1(S_out1), .S_out0(S_out0), .load_err(load_err)
   );

   always #5 clk = ~clk;

   assign now_t = {2'b00, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_in(input logic [15:0] hm);
      H_in1 = hm[13:12];
      H_in0 = hm[11:8];
      M_in1 = hm[7:4];
      M_in0 = hm[3:0];
   endtask

   task automatic load_time(input logic [15:0] hm);
      set_in(hm);
      LD_time = 1'b1;
      step(1);
      LD_time = 1'b0;
   endtask

   task automatic load_alarm(input logic [2:0] sel, input logic [15:0] hm);
      set_in(hm);
      al_sel = sel;
      LD_alarm = 1'b1;
      step(1);
      LD_alarm = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      step(2);
      #1;
      check("rst_time", 32'(now_t), 32'h000000);
      check("rst_alarm", 32'(Alarm), 32'h0);
      check("rst_err", 32'(load_err), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // async reset mid-count at 12:34:56
      load_time(16'h1234);
      step(56);
      check("pre_rst", 32'(now_t), 32'h123456);
      #2 reset = 1'b0;
      #1;
      check("async_time", 32'(now_t), 32'h000000);
      check("async_alarm", 32'(Alarm), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // rollover 23:59:59 -> 00:00:00
      load_time(16'h2359);
      check("ld_2359", 32'(now_t), 32'h235900);
      step(59);
      check("t_235959", 32'(now_t), 32'h235959);
      step(1);
      check("t_wrap", 32'(now_t), 32'h000000);
      check("wrap_err", 32'(load_err), 32'h0);

      // two channels ringing together, auto stop after 3 s
      load_alarm(3'd0, 16'h1001);
      load_alarm(3'd2, 16'h1001);
      AL_ON = 4'b0101;
      load_time(16'h1000);
      step(59);
      check("multi_pre", 32'(Alarm), 32'h0);
      step(1);
      check("multi_t", 32'(now_t), 32'h100100);
      check("multi_ring", 32'(Alarm), 32'h5);
      step(2);
      check("multi_ring2", 32'(Alarm), 32'h5);
      step(1);
      check("multi_auto", 32'(Alarm), 32'h0);

      // stop, stop beating a same-cycle trigger, disarm while ringing
      load_alarm(3'd1, 16'h1100);
      load_alarm(3'd3, 16'h1101);
      AL_ON = 4'b1010;
      load_time(16'h1059);
      step(60);
      check("ch1_ring", 32'(Alarm), 32'h2);
      step(1);
      STOP_al = 1'b1;
      step(1);
      STOP_al = 1'b0;
      check("stop", 32'(Alarm), 32'h0);
      load_time(16'h1100);
      check("ld_no_trig", 32'(Alarm), 32'h0);
      step(59);
      STOP_al = 1'b1;
      step(1);
      STOP_al = 1'b0;
      check("stop_t", 32'(now_t), 32'h110100);
      check("stop_vs_trig", 32'(Alarm), 32'h0);
      step(1);
      check("stop_vs_trig2", 32'(Alarm), 32'h0);
      load_alarm(3'd1, 16'h1102);
      load_time(16'h1101);
      step(60);
      check("ch1_ring2", 32'(Alarm), 32'h2);
      AL_ON = 4'b1000;
      step(1);
      check("disarm", 32'(Alarm), 32'h0);

      // rejected loads
      AL_ON = 4'b0000;
      load_time(16'h0500);
      load_time(16'h2400);
      check("bad_time_err", 32'(load_err), 32'h1);
      check("bad_time_t", 32'(now_t), 32'h050001);
      step(1);
      check("err_pulse", 32'(load_err), 32'h0);
      load_alarm(3'd0, 16'h1260);
      check("bad_min_err", 32'(load_err), 32'h1);
      load_alarm(3'd4, 16'h0900);
      check("bad_sel_err", 32'(load_err), 32'h1);
      AL_ON = 4'b0001;
      load_time(16'h0859);
      check("good_ld_err", 32'(load_err), 32'h0);
      step(60);
      check("sel4_ignored", 32'(Alarm), 32'h0);
      load_time(16'h1259);
      step(60);
      check("m60_t", 32'(now_t), 32'h130000);
      check("m60_ignored", 32'(Alarm), 32'h0);
      load_time(16'h1000);
      step(60);
      check("ch0_kept", 32'(Alarm), 32'h1);
      STOP_al = 1'b1;
      step(1);
      STOP_al = 1'b0;

`ifdef ACLK_SNOOZE_EN
      // snooze across midnight
      load_alarm(3'd0, 16'h2357);
      AL_ON = 4'b0001;
      load_time(16'h2356);
      step(60);
      check("snz_ring", 32'(Alarm), 32'h1);
      step(1);
      SNOOZE = 1'b1;
      step(1);
      SNOOZE = 1'b0;
      check("snz_quiet", 32'(Alarm), 32'h0);
      step(297);
      check("snz_t", 32'(now_t), 32'h000159);
      check("snz_wait", 32'(Alarm), 32'h0);
      step(1);
      check("snz_rering", 32'(Alarm), 32'h1);
      STOP_al = 1'b1;
      step(1);
      STOP_al = 1'b0;
      check("snz_stop", 32'(Alarm), 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
